// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_REGS   = 32;
   localparam int ZERO_REG           = 0;

   // Index width for n entries; at least one bit so a 2-entry file still has an address.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side bundle of the register file: write port, busy set, read ports and status.
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int NUM_REGS   = DEFAULT_NUM_REGS,
   parameter int NUM_READ   = 2
);
   localparam int ADDR_W = clog2(NUM_REGS);

   logic                         ctrl_writeEnable;
   logic [ADDR_W-1:0]            ctrl_writeReg;
   logic [DATA_WIDTH-1:0]        data_writeReg;
   logic                         ctrl_setBusy;
   logic [ADDR_W-1:0]            ctrl_busyReg;
   logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg;
   logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
   logic [NUM_READ-1:0]          read_busy;
   logic                         any_busy;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_setBusy, ctrl_busyReg, ctrl_readReg,
      input  data_readReg, read_busy, any_busy
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_setBusy, ctrl_busyReg, ctrl_readReg,
      output data_readReg, read_busy, any_busy
   );

endinterface

// File: rtl/regfile_busy_table.sv
// One pending-write bit per register; a set in the same cycle as a clear wins.
module regfile_busy_table
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int ADDR_W   = clog2(NUM_REGS)
) (
   input  logic                clock_i,
   input  logic                reset_n_i,
   input  logic                set_i,
   input  logic [ADDR_W-1:0]   set_idx_i,
   input  logic                clr_i,
   input  logic [ADDR_W-1:0]   clr_idx_i,
   output logic [NUM_REGS-1:0] busy_o,
   output logic                any_busy_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                any_busy_q;

   // Set is applied after clear so a newly issued producer supersedes the writeback.
   always_comb begin
      busy_d = busy_q;
      if (clr_i) busy_d[clr_idx_i] = 1'b0;
      if (set_i) busy_d[set_idx_i] = 1'b1;
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         busy_q     <= '0;
         any_busy_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         any_busy_q <= |busy_d;
      end
   end

   assign busy_o     = busy_q;
   assign any_busy_o = any_busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with optional write bypass and per-register busy tracking.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int NUM_REGS   = DEFAULT_NUM_REGS,
   parameter int NUM_READ   = 2,
   parameter int BYPASS     = 1
) (
   input logic                  clock,
   input logic                  ctrl_reset_n,
   regfile_scoreboard_if.slave  bus
);

   localparam int ADDR_W = clog2(NUM_REGS);
   localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

   // Excludes the hardwired zero register and indices past the end of a non-power-of-two file.
   function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
      return ({1'b0, idx} < REG_LIMIT) && (idx != ADDR_W'(ZERO_REG));
   endfunction

   logic                  wr_valid;
   logic                  set_valid;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;
   logic                  any_busy;

   assign wr_valid  = bus.ctrl_writeEnable && idx_ok(bus.ctrl_writeReg);
   assign set_valid = bus.ctrl_setBusy && idx_ok(bus.ctrl_busyReg);

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_valid) begin
         regs_q[bus.ctrl_writeReg] <= bus.data_writeReg;
      end
   end

   regfile_busy_table #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_busy (
      .clock_i    (clock),
      .reset_n_i  (ctrl_reset_n),
      .set_i      (set_valid),
      .set_idx_i  (bus.ctrl_busyReg),
      .clr_i      (wr_valid),
      .clr_idx_i  (bus.ctrl_writeReg),
      .busy_o     (busy),
      .any_busy_o (any_busy)
   );

   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_W-1:0] idx;
      logic              hit;
      logic              fwd;
      logic              reset_busy;

      assign idx = bus.ctrl_readReg[gi*ADDR_W +: ADDR_W];
      assign hit = idx_ok(idx);
      assign fwd = (BYPASS != 0) && wr_valid && (bus.ctrl_writeReg == idx);
      // A forwarded writeback retires the pending bit early unless a new producer claims it now.
      assign reset_busy = fwd && !(set_valid && (bus.ctrl_busyReg == idx));

      assign bus.data_readReg[gi*DATA_WIDTH +: DATA_WIDTH] =
         fwd ? bus.data_writeReg : (hit ? regs_q[idx] : '0);
      assign bus.read_busy[gi] = hit && busy[idx] && !reset_busy;
   end

   assign bus.any_busy = any_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of a bypassing 24-entry file and a non-bypassing 16-bit, 4-port file.
module tb_regfile_scoreboard;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   regfile_scoreboard_if #(.DATA_WIDTH(32), .NUM_REGS(24), .NUM_READ(2)) b0 ();
   regfile_scoreboard_if #(.DATA_WIDTH(16), .NUM_REGS(8),  .NUM_READ(4)) b1 ();

   regfile_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(24), .NUM_READ(2), .BYPASS(1)) u0 (
      .clock        (clk),
      .ctrl_reset_n (rst_n),
      .bus          (b0)
   );

   regfile_scoreboard #(.DATA_WIDTH(16), .NUM_REGS(8), .NUM_READ(4), .BYPASS(0)) u1 (
      .clock        (clk),
      .ctrl_reset_n (rst_n),
      .bus          (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      b0.ctrl_writeEnable = 1'b0;
      b0.ctrl_setBusy     = 1'b0;
   endtask

   task automatic idle1();
      b1.ctrl_writeEnable = 1'b0;
      b1.ctrl_setBusy     = 1'b0;
   endtask

   task automatic wr0(input logic [4:0] r, input logic [31:0] d);
      b0.ctrl_writeEnable = 1'b1;
      b0.ctrl_writeReg    = r;
      b0.data_writeReg    = d;
   endtask

   task automatic set0(input logic [4:0] r);
      b0.ctrl_setBusy = 1'b1;
      b0.ctrl_busyReg = r;
   endtask

   task automatic wr1(input logic [2:0] r, input logic [15:0] d);
      b1.ctrl_writeEnable = 1'b1;
      b1.ctrl_writeReg    = r;
      b1.data_writeReg    = d;
   endtask

   initial begin
      rst_n = 1'b0;
      idle0();
      idle1();
      b0.ctrl_writeReg = '0; b0.data_writeReg = '0; b0.ctrl_busyReg = '0; b0.ctrl_readReg = '0;
      b1.ctrl_writeReg = '0; b1.data_writeReg = '0; b1.ctrl_busyReg = '0; b1.ctrl_readReg = '0;
      #2;
      check("rst_data", b0.data_readReg, 64'h0);
      check("rst_rbusy", b0.read_busy, 64'h0);
      check("rst_any", b0.any_busy, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // r5 written, r4 marked busy, then asynchronous reset mid-cycle
      wr0(5'd5, 32'hDEADBEEF);
      set0(5'd4);
      b0.ctrl_readReg = {5'd4, 5'd5};
      #1 check("byp_r5", b0.data_readReg[31:0], 64'hDEADBEEF);
      tick(); idle0();
      #1;
      check("st_r5", b0.data_readReg[31:0], 64'hDEADBEEF);
      check("busy_r4", b0.read_busy, 64'h2);
      check("any_r4", b0.any_busy, 64'h1);
      rst_n = 1'b0;
      #1;
      check("arst_r5", b0.data_readReg[31:0], 64'h0);
      check("arst_rbusy", b0.read_busy, 64'h0);
      check("arst_any", b0.any_busy, 64'h0);
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_r5", b0.data_readReg[31:0], 64'h0);

      // r7 read on both ports
      wr0(5'd7, 32'h12345678);
      b0.ctrl_readReg = {5'd7, 5'd7};
      #1 check("byp_r7", b0.data_readReg, {2{32'h12345678}});
      tick(); idle0();
      #1 check("st_r7", b0.data_readReg, {2{32'h12345678}});

      // Zero register and out-of-range index
      wr0(5'd0, 32'hFFFFFFFF);
      set0(5'd0);
      b0.ctrl_readReg = {5'd0, 5'd0};
      #1 check("r0_byp", b0.data_readReg, 64'h0);
      tick(); idle0();
      wr0(5'd30, 32'h11);
      set0(5'd30);
      b0.ctrl_readReg = {5'd0, 5'd30};
      #1;
      check("r30_byp", b0.data_readReg, 64'h0);
      check("r30_rbusy", b0.read_busy, 64'h0);
      tick(); idle0();
      #1;
      check("r0_r30", b0.data_readReg, 64'h0);
      check("range_rbusy", b0.read_busy, 64'h0);
      check("range_any", b0.any_busy, 64'h0);

      // Scoreboard: busy r3 for four idle cycles, then writeback
      set0(5'd3);
      b0.ctrl_readReg = {5'd7, 5'd3};
      #1 check("sb_pre", b0.read_busy, 64'h0);
      tick(); idle0();
      for (int k = 1; k <= 4; k++) begin
         #1;
         check($sformatf("sb_rb_c%0d", k), b0.read_busy, 64'h1);
         check($sformatf("sb_any_c%0d", k), b0.any_busy, 64'h1);
         tick();
      end
      wr0(5'd3, 32'hA5A5A5A5);
      #1;
      check("sb_wb_rbusy", b0.read_busy, 64'h0);
      check("sb_wb_data", b0.data_readReg[31:0], 64'hA5A5A5A5);
      check("sb_wb_any", b0.any_busy, 64'h1);
      tick(); idle0();
      #1;
      check("sb_done_any", b0.any_busy, 64'h0);
      check("sb_done_data", b0.data_readReg, {32'h12345678, 32'hA5A5A5A5});

      // Collision: set and write r9 in the same cycle
      wr0(5'd9, 32'h55);
      set0(5'd9);
      b0.ctrl_readReg = {5'd9, 5'd7};
      #1 check("col_pre_rb", b0.read_busy, 64'h0);
      tick(); idle0();
      #1;
      check("col_data", b0.data_readReg, {32'h55, 32'h12345678});
      check("col_rbusy", b0.read_busy, 64'h2);
      check("col_any", b0.any_busy, 64'h1);
      wr0(5'd9, 32'h66);
      set0(5'd9);
      #1;
      check("col2_rbusy", b0.read_busy, 64'h2);
      check("col2_byp", b0.data_readReg[63:32], 64'h66);
      tick(); idle0();
      #1 check("col2_after", b0.read_busy, 64'h2);
      wr0(5'd9, 32'h77);
      #1;
      check("wb9_rbusy", b0.read_busy, 64'h0);
      check("wb9_any", b0.any_busy, 64'h1);
      tick(); idle0();
      #1;
      check("wb9_any_clr", b0.any_busy, 64'h0);
      check("wb9_data", b0.data_readReg[63:32], 64'h77);

      // Non-bypassing instance: write visible next cycle, busy drops next cycle
      b1.ctrl_readReg = {3'd2, 3'd2, 3'd2, 3'd2};
      wr1(3'd2, 16'hBEEF);
      #1 check("nb_same", b1.data_readReg, 64'h0);
      tick(); idle1();
      #1 check("nb_next", b1.data_readReg, {4{16'hBEEF}});
      b1.ctrl_setBusy = 1'b1;
      b1.ctrl_busyReg = 3'd5;
      tick(); idle1();
      b1.ctrl_readReg = {3'd0, 3'd2, 3'd5, 3'd5};
      #1;
      check("nb_rbusy", b1.read_busy, 64'h3);
      check("nb_any", b1.any_busy, 64'h1);
      wr1(3'd5, 16'h1234);
      #1;
      check("nb_wb_rbusy", b1.read_busy, 64'h3);
      check("nb_wb_data", b1.data_readReg[15:0], 64'h0);
      tick(); idle1();
      #1;
      check("nb_clr_rbusy", b1.read_busy, 64'h0);
      check("nb_clr_any", b1.any_busy, 64'h0);
      check("nb_all_ports", b1.data_readReg, {16'h0, 16'hBEEF, 16'h1234, 16'h1234});
      wr1(3'd7, 16'h7777);
      tick(); idle1();
      b1.ctrl_readReg = {3'd7, 3'd0, 3'd2, 3'd7};
      #1 check("nb_top_reg", b1.data_readReg, {16'h7777, 16'h0, 16'hBEEF, 16'h7777});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
